// File: rtl/dsm_pkg.sv
// Shared types, constants and helpers for the delta-sigma loop sequencer.
// Fixed-point formats: samples Q4.15, coefficients Q1.23, accumulator Q12.15.
package dsm_pkg;

    localparam int N_STATES   = 4;
    localparam int DW         = 20;
    localparam int CW         = 25;
    localparam int AW         = 28;
    localparam int PW         = DW + CW;
    localparam int FRAC_SHIFT = 23;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [AW-1:0] acc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC_Y,
        S_MAC_X,
        S_COMMIT
    } state_t;

    localparam coef_t A0_DEF [N_STATES] = '{
        25'h1FFEB6B, 25'h10040AB, 25'h1FFEB6B, 25'h1800000
    };
    localparam coef_t C_DEF [N_STATES] = '{
        25'h18F5D27, 25'h0088055, 25'h1B21A18, 25'h0032FC9
    };
    localparam coef_t D_DEF = 25'h1FCD037;

    localparam sample_t FB_POS  = 20'h04000;
    localparam sample_t FB_NEG  = 20'hFC000;
    localparam sample_t SAT_MAX = 20'h7FFFF;
    localparam sample_t SAT_MIN = 20'h80000;

    function automatic logic sat_clips(input acc_t v);
        return (v > acc_t'(SAT_MAX)) || (v < acc_t'(SAT_MIN));
    endfunction

    function automatic sample_t sat20(input acc_t v);
        if (v > acc_t'(SAT_MAX)) return SAT_MAX;
        if (v < acc_t'(SAT_MIN)) return SAT_MIN;
        return v[DW-1:0];
    endfunction

endpackage

// File: rtl/dsm_mac.sv
// Shared multiply-accumulate: (x*c)>>>23 plus an addend into the accumulator.
// Ports: clk, reset, en, clear (restart sum), x, c, addend, acc (registered).
module dsm_mac
    import dsm_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    en,
    input  logic    clear,
    input  sample_t x,
    input  coef_t   c,
    input  acc_t    addend,
    output acc_t    acc
);

    logic signed [PW-1:0] ext_x;
    logic signed [PW-1:0] ext_c;
    logic signed [PW-1:0] prod;
    acc_t                 prod_sh;
    acc_t                 acc_d;
    acc_t                 acc_q;

    always_comb begin
        ext_x   = {{CW{x[DW-1]}}, x};
        ext_c   = {{DW{c[CW-1]}}, c};
        prod    = ext_x * ext_c;
        // Floor shift; the result fits well inside AW bits.
        prod_sh = acc_t'(prod >>> FRAC_SHIFT);
        acc_d   = acc_q;
        if (en) begin
            acc_d = (clear ? '0 : acc_q) + prod_sh + addend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dsm_loop_sequencer.sv
// Time-multiplexed DSS loop controller driving a 1-bit PWM quantizer.
// Ports: clk, reset (sync, high), in_valid/in_ready/in_data sample input,
// pwm, pwm_valid, y_dbg, sat outputs. Macro DSM_COEF_WR_EN adds
// coef_we/coef_addr/coef_wdata for a writable coefficient file.
module dsm_loop_sequencer
    import dsm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          pwm,
    output logic          pwm_valid,
    output logic [DW-1:0] y_dbg,
    output logic          sat
`ifdef DSM_COEF_WR_EN
    ,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_wdata
`endif
);

    state_t  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    sample_t u_q, u_d;
    sample_t vin_q, vin_d;
    sample_t y_q, y_d;
    sample_t y_dbg_q, y_dbg_d;
    sample_t x_q [N_STATES];
    sample_t x_d [N_STATES];
    logic    pwm_q, pwm_d;
    logic    pwm_valid_q, pwm_valid_d;
    logic    sat_q, sat_d;
    logic    clip_q, clip_d;

    coef_t   a0_v [N_STATES];
    coef_t   c_v  [N_STATES];
    coef_t   d_v;

    logic    mac_en, mac_clear;
    sample_t mac_x;
    coef_t   mac_c;
    acc_t    mac_add, mac_acc;

    sample_t             fb;
    logic signed [DW:0]  diff;
    logic signed [DW:0]  sum_s;
    logic [1:0]          sel;

`ifdef DSM_COEF_WR_EN
    coef_t a0_q [N_STATES];
    coef_t a0_d [N_STATES];
    coef_t c_q  [N_STATES];
    coef_t c_d  [N_STATES];
    coef_t d_q, d_d;

    always_comb begin
        a0_d = a0_q;
        c_d  = c_q;
        d_d  = d_q;
        // Writes only land while idle and no sample is being taken.
        if (coef_we && state_q == S_IDLE && !in_valid) begin
            if (coef_addr < 4'd4) begin
                a0_d[coef_addr[1:0]] = coef_wdata;
            end else if (coef_addr < 4'd8) begin
                c_d[coef_addr[1:0]] = coef_wdata;
            end else if (coef_addr == 4'd8) begin
                d_d = coef_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a0_q <= A0_DEF;
            c_q  <= C_DEF;
            d_q  <= D_DEF;
        end else begin
            a0_q <= a0_d;
            c_q  <= c_d;
            d_q  <= d_d;
        end
    end

    assign a0_v = a0_q;
    assign c_v  = c_q;
    assign d_v  = d_q;
`else
    assign a0_v = A0_DEF;
    assign c_v  = C_DEF;
    assign d_v  = D_DEF;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        u_d         = u_q;
        vin_d       = vin_q;
        y_d         = y_q;
        y_dbg_d     = y_dbg_q;
        x_d         = x_q;
        pwm_d       = pwm_q;
        pwm_valid_d = 1'b0;
        sat_d       = 1'b0;
        clip_d      = clip_q;
        sel         = idx_q[1:0];
        mac_en      = 1'b0;
        mac_clear   = (idx_q == 3'd0);
        mac_x       = x_q[sel];
        mac_c       = c_v[sel];
        mac_add     = '0;
        fb          = pwm_q ? FB_POS : FB_NEG;
        diff        = {in_data[DW-1], in_data} - {fb[DW-1], fb};
        sum_s       = {y_q[DW-1], y_q} + {vin_q[DW-1], vin_q};

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    u_d     = sat20(acc_t'(diff));
                    clip_d  = sat_clips(acc_t'(diff));
                    vin_d   = in_data;
                    idx_d   = 3'd0;
                    state_d = S_MAC_Y;
                end
            end
            S_MAC_Y: begin
                mac_en = 1'b1;
                if (idx_q == 3'(N_STATES)) begin
                    mac_x   = u_q;
                    mac_c   = d_v;
                    idx_d   = 3'd0;
                    state_d = S_MAC_X;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_MAC_X: begin
                mac_en = 1'b1;
                mac_c  = a0_v[sel];
                // Accumulator still holds the finished y sum here.
                if (idx_q == 3'd0) begin
                    y_d    = sat20(mac_acc);
                    clip_d = clip_q | sat_clips(mac_acc);
                end
                if (idx_q == 3'(N_STATES - 1)) begin
                    mac_add = acc_t'(u_q);
                    state_d = S_COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_COMMIT: begin
                x_d[0] = sat20(mac_acc);
                for (int i = 1; i < N_STATES; i++) begin
                    x_d[i] = x_q[i-1];
                end
                // Quantizer follows the sign of the unsaturated y + vin.
                pwm_d       = (sum_s < 0);
                y_dbg_d     = y_q;
                pwm_valid_d = 1'b1;
                sat_d       = clip_q | sat_clips(mac_acc);
                clip_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            u_q         <= '0;
            vin_q       <= '0;
            y_q         <= '0;
            y_dbg_q     <= '0;
            x_q         <= '{default: '0};
            pwm_q       <= 1'b0;
            pwm_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            u_q         <= u_d;
            vin_q       <= vin_d;
            y_q         <= y_d;
            y_dbg_q     <= y_dbg_d;
            x_q         <= x_d;
            pwm_q       <= pwm_d;
            pwm_valid_q <= pwm_valid_d;
            sat_q       <= sat_d;
            clip_q      <= clip_d;
        end
    end

    dsm_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .en     (mac_en),
        .clear  (mac_clear),
        .x      (mac_x),
        .c      (mac_c),
        .addend (mac_add),
        .acc    (mac_acc)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign pwm       = pwm_q;
    assign pwm_valid = pwm_valid_q;
    assign y_dbg     = y_dbg_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_dsm_loop_sequencer.sv
// Directed self-checking bench for dsm_loop_sequencer with a
// bit-exact reference model of the DSS loop.
module tb_dsm_loop_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [19:0] in_data;
    logic        in_ready;
    logic        pwm;
    logic        pwm_valid;
    logic [19:0] y_dbg;
    logic        sat;
`ifdef DSM_COEF_WR_EN
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [24:0] coef_wdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    longint m_x  [4];
    longint m_a0 [4];
    longint m_c  [4];
    longint m_d;
    bit     m_pwm;

    always #5 clk = ~clk;

    dsm_loop_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pwm       (pwm),
        .pwm_valid (pwm_valid),
        .y_dbg     (y_dbg),
        .sat       (sat)
`ifdef DSM_COEF_WR_EN
        ,
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata)
`endif
    );

    function automatic longint c25(input logic [24:0] h);
        return h[24] ? longint'(h) - 64'sd33554432 : longint'(h);
    endfunction

    function automatic longint s20(input logic [19:0] h);
        return h[19] ? longint'(h) - 64'sd1048576 : longint'(h);
    endfunction

    function automatic longint clamp(input longint v, inout bit clip);
        if (v > 524287) begin
            clip = 1'b1;
            return 524287;
        end
        if (v < -524288) begin
            clip = 1'b1;
            return -524288;
        end
        return v;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 4; i++) m_x[i] = 0;
        m_pwm   = 1'b0;
        m_a0[0] = c25(25'h1FFEB6B);
        m_a0[1] = c25(25'h10040AB);
        m_a0[2] = c25(25'h1FFEB6B);
        m_a0[3] = c25(25'h1800000);
        m_c[0]  = c25(25'h18F5D27);
        m_c[1]  = c25(25'h0088055);
        m_c[2]  = c25(25'h1B21A18);
        m_c[3]  = c25(25'h0032FC9);
        m_d     = c25(25'h1FCD037);
    endtask

    task automatic model_step(input longint vin, output bit e_pwm,
                              output logic [19:0] e_y, output bit e_sat);
        longint fb, u, acc, y, xn;
        bit clip;
        clip = 1'b0;
        fb   = m_pwm ? 64'sd16384 : -64'sd16384;
        u    = clamp(vin - fb, clip);
        acc  = 0;
        for (int i = 0; i < 4; i++) acc += (m_c[i] * m_x[i]) >>> 23;
        acc += (m_d * u) >>> 23;
        y    = clamp(acc, clip);
        acc  = 0;
        for (int i = 0; i < 4; i++) acc += (m_a0[i] * m_x[i]) >>> 23;
        xn   = clamp(acc + u, clip);
        for (int i = 3; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = xn;
        m_pwm  = (y + vin) < 0;
        e_pwm  = m_pwm;
        e_y    = y[19:0];
        e_sat  = clip;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Offers one sample, returns cycles from accept to pwm_valid.
    task automatic run_sample(input logic [19:0] vin, output int lat);
        int w;
        w        = 0;
        in_data  = vin;
        in_valid = 1'b1;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 20'h5A5A5;
        lat      = 1;
        while (!pwm_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_tests++;
        if (pwm !== 1'b0 || pwm_valid !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: pwm %b pv %b sat %b want 0 0 0",
                     pwm, pwm_valid, sat);
        end
        n_tests++;
        if (y_dbg !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_y_dbg: got %h want 00000", y_dbg);
        end
        model_reset();
    endtask

    task automatic test_first_sample;
        int lat;
        do_reset();
        run_sample(20'h00000, lat);
        n_tests++;
        if (lat != 11) begin
            n_fail++;
            $display("FAIL first_latency: got %0d want 11", lat);
        end
        n_tests++;
        if (pwm !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pwm: got %b want 1", pwm);
        end
        n_tests++;
        if (y_dbg !== 20'hFFE68) begin
            n_fail++;
            $display("FAIL first_y_dbg: got %h want ffe68", y_dbg);
        end
        n_tests++;
        if (sat !== 1'b0) begin
            n_fail++;
            $display("FAIL first_sat: got %b want 0", sat);
        end
        n_tests++;
        if (dut.x_q[0] !== 20'h04000) begin
            n_fail++;
            $display("FAIL first_x0: got %h want 04000", dut.x_q[0]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (pwm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_pv_pulse: got %b want 0", pwm_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic rdy [35];
        logic pv  [35];
        int   acc_cnt, pulses, busy_hi;
        do_reset();
        acc_cnt  = 0;
        pulses   = 0;
        busy_hi  = 0;
        in_data  = '0;
        in_valid = 1'b1;
        for (int c = 0; c < 35; c++) begin
            rdy[c] = in_ready;
            pv[c]  = pwm_valid;
            if (pwm_valid === 1'b1) pulses++;
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk); #1;
            if (acc_cnt == 3) in_valid = 1'b0;
        end
        for (int c = 1; c <= 10; c++) begin
            if (rdy[c] !== 1'b0) busy_hi++;
        end
        n_tests++;
        if (acc_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d want 3", acc_cnt);
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d want 3", pulses);
        end
        n_tests++;
        if (busy_hi != 0) begin
            n_fail++;
            $display("FAIL b2b_busy_ready: got %0d high want 0", busy_hi);
        end
        n_tests++;
        if (rdy[11] !== 1'b1 || rdy[22] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_ret: got %b %b want 1 1",
                     rdy[11], rdy[22]);
        end
        n_tests++;
        if (pv[11] !== 1'b1 || pv[22] !== 1'b1 || pv[33] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pv_pos: got %b %b %b want 1 1 1",
                     pv[11], pv[22], pv[33]);
        end
    endtask

    task automatic test_saturation;
        int          lat;
        bit          ep, es;
        logic [19:0] ey;
        do_reset();
        model_step(s20(20'h7FFFF), ep, ey, es);
        run_sample(20'h7FFFF, lat);
        n_tests++;
        if (lat != 11 || sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pulse: lat %0d sat %b want 11 1", lat, sat);
        end
        n_tests++;
        if (pwm !== ep || y_dbg !== ey) begin
            n_fail++;
            $display("FAIL sat_out: pwm %b y %h want %b %h",
                     pwm, y_dbg, ep, ey);
        end
        @(posedge clk); #1;
        n_tests++;
        if (sat !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_width: got %b want 0", sat);
        end
        model_step(0, ep, ey, es);
        run_sample(20'h00000, lat);
        n_tests++;
        if (sat !== es || pwm !== ep || y_dbg !== ey) begin
            n_fail++;
            $display("FAIL sat_next: sat %b pwm %b y %h want %b %b %h",
                     sat, pwm, y_dbg, es, ep, ey);
        end
    endtask

    task automatic test_reset_abort;
        int lat, nz, pvs;
        do_reset();
        run_sample(20'h00000, lat);
        n_tests++;
        if (pwm !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_pwm: got %b want 1", pwm);
        end
        in_data  = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: got %b want 1", in_ready);
        end
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            if (dut.x_q[i] !== 20'h0) nz++;
        end
        n_tests++;
        if (pwm !== 1'b0 || nz != 0 || y_dbg !== 20'h0) begin
            n_fail++;
            $display("FAIL abort_state: pwm %b nzx %0d y %h want 0 0 0",
                     pwm, nz, y_dbg);
        end
        pvs = 0;
        repeat (15) begin
            if (pwm_valid !== 1'b0) pvs++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (pvs != 0) begin
            n_fail++;
            $display("FAIL abort_no_pv: got %0d pulses want 0", pvs);
        end
        model_reset();
    endtask

`ifdef DSM_COEF_WR_EN
    task automatic test_coef_write;
        int          lat;
        bit          ep, es;
        logic [19:0] ey;
        do_reset();
        coef_we    = 1'b1;
        coef_addr  = 4'd8;
        coef_wdata = '0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        m_d     = 0;
        model_step(0, ep, ey, es);
        run_sample(20'h00000, lat);
        n_tests++;
        if (y_dbg !== 20'h0 || pwm !== 1'b0) begin
            n_fail++;
            $display("FAIL coef_d0: y %h pwm %b want 00000 0", y_dbg, pwm);
        end
        model_step(0, ep, ey, es);
        in_data  = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        coef_we    = 1'b1;
        coef_addr  = 4'd8;
        coef_wdata = 25'h1FCD037;
        @(posedge clk); #1;
        coef_we = 1'b0;
        lat     = 2;
        while (!pwm_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 11 || pwm !== ep || y_dbg !== ey) begin
            n_fail++;
            $display("FAIL coef_busy_wr: lat %0d pwm %b y %h want 11 %b %h",
                     lat, pwm, y_dbg, ep, ey);
        end
    endtask
`endif

    task automatic test_stream;
        int          lat, ones, toggles, bal;
        bit          ep, es, prev;
        logic [19:0] ey;
        do_reset();
        ones    = 0;
        toggles = 0;
        prev    = 1'b0;
        for (int k = 0; k < 100; k++) begin
            model_step(0, ep, ey, es);
            run_sample(20'h00000, lat);
            n_tests++;
            if (lat != 11 || pwm !== ep || y_dbg !== ey || sat !== es) begin
                n_fail++;
                $display("FAIL stream_%0d: lat %0d pwm %b y %h sat %b want 11 %b %h %b",
                         k, lat, pwm, y_dbg, sat, ep, ey, es);
            end
            if (pwm === 1'b1) ones++;
            if (pwm !== prev) toggles++;
            prev = pwm;
        end
        bal = 2 * ones - 100;
        n_tests++;
        if (bal > 5 || bal < -5) begin
            n_fail++;
            $display("FAIL stream_mean: sum %0d/100 want within +-5", bal);
        end
        n_tests++;
        if (toggles == 0) begin
            n_fail++;
            $display("FAIL stream_toggle: got %0d toggles want >0", toggles);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef DSM_COEF_WR_EN
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
`endif
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_saturation();
        test_reset_abort();
`ifdef DSM_COEF_WR_EN
        test_coef_write();
`endif
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
